// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. It owns the PC and drives the address
// of the combinational instruction memory. Each returned word is buffered with
// its PC in a small FIFO, and the FIFO head is offered to decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_EN. When it is defined, a push from a
// misaligned PC enqueues a NOP tagged with out_misalign=1 and halts fetch until
// the next redirect or reset. When it is undefined, loaded PCs are forced word-aligned.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

`ifdef FETCH_MISALIGN_EN
  localparam logic [31:0] RESET_PC_LD = RESET_PC;
`else
  localparam logic [31:0] RESET_PC_LD = RESET_PC & 32'hFFFF_FFFC;
`endif

  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   buf_inst [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [31:0]   redirect_ld;
  logic [31:0]   wr_inst;
  logic          pop;
  logic          push;
  logic          halted;

`ifdef FETCH_MISALIGN_EN
  logic buf_mis [FIFO_DEPTH];
  logic halt;
  logic wr_mis;

  assign redirect_ld = redirect_pc;
  assign wr_mis      = (pc[1:0] != 2'b00);
  assign wr_inst     = wr_mis ? NOP : imem_inst;
  assign halted      = halt;
`else
  assign redirect_ld = redirect_pc & 32'hFFFF_FFFC;
  assign wr_inst     = imem_inst;
  assign halted      = 1'b0;
`endif

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ~halted & ((count < DEPTH_C) | pop);

  // PC, FIFO pointers and occupancy; a redirect flushes and cancels that cycle's pop/push
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC_LD;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_ld;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; only pointers/count need reset since occupancy gates all reads
  always_ff @(posedge clk) begin
    if (push & ~rst) begin
      buf_inst[tail] <= wr_inst;
      buf_pc[tail]   <= pc;
`ifdef FETCH_MISALIGN_EN
      buf_mis[tail]  <= wr_mis;
`endif
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Halt latch: set by a misaligned push, cleared only by reset or redirect
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      halt <= 1'b0;
    end else if (push && wr_mis) begin
      halt <= 1'b1;
    end
  end

  assign out_misalign = out_valid ? buf_mis[head] : 1'b0;
`endif

  assign out_inst = out_valid ? buf_inst[head] : NOP;
  assign out_pc   = out_valid ? buf_pc[head]   : 32'h0000_0000;
  assign out_pc4  = out_pc + 32'd4;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RISC-V core. It sits directly upstream of the byte-addressed, combinational-read instruction memory.
- Owns the PC register and drives the memory address. It captures the returned 32-bit instruction together with its PC into a small FIFO, then presents the pair downstream to decode over a valid/ready handshake.
- Handles stalls from decode and redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; legal values are 2 or 4.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to the instruction memory; equals the PC register (combinational from the register).
- imem_inst  input  32  instruction word returned combinationally by the memory for imem_addr, already assembled little-endian.
- redirect_valid  input  1  branch/jump taken; flushes the stage.
- redirect_pc  input  32  target PC, sampled when redirect_valid=1.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  instruction at the FIFO head.
- out_pc  output  32  PC of out_inst.
- out_pc4  output  32  out_pc+4, modulo 2^32.
- out_misalign  output  1  present only with FETCH_MISALIGN_EN; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc<=RESET_PC, count<=0, FIFO pointers<=0, halt flag<=0.
  - Outputs: out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=0, out_pc4=4, out_misalign=0.
  - Reset has priority over every other input. A reset mid-stream discards all buffered entries.
- Fetch, per cycle:
  - pop = out_valid & out_ready.
  - push = ~redirect_valid & ~halt & (count<FIFO_DEPTH | pop).
  - On push: write {pc, imem_inst} at the tail, then pc<=pc+4. The increment wraps, so 32'hFFFF_FFFC -> 32'h0000_0000.
  - With no push, pc holds.
- Handshake:
  - out_valid = (count!=0).
  - out_inst, out_pc and out_pc4 come from the head entry. When count==0 they are NOP / 0 / 4.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - out_valid does not depend combinationally on out_ready.
- Latency:
  - An instruction fetched in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Full: count==FIFO_DEPTH with no pop means no push, and imem_addr holds its value.
- Simultaneous push and pop when full is allowed; count is unchanged.
- Empty: a pop cannot occur; only a push is possible.
- Redirect (redirect_valid=1, no rst):
  - Flush all entries: count<=0, pointers<=0.
  - pc<=redirect_pc. The pop and push of that cycle are cancelled.
  - out_valid=0 in cycle N+1, first fetch from redirect_pc in cycle N+1, out_valid=1 in cycle N+2.
  - Redirect overrides a full FIFO or a stall.
  - Back-to-back redirects: the last one wins.
- Pointer arithmetic: head/tail pointers are log2(FIFO_DEPTH) bits wide, with natural wrap. count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Defined:
  - Each FIFO entry carries a misalign bit; the out_misalign port exists.
  - If pc[1:0]!=2'b00 at push time, the entry is pushed with inst=32'h0000_0013 and misalign=1.
  - Then halt<=1: no further pushes until the next redirect or reset.
  - out_misalign reflects the head entry and is 0 when empty.
- Undefined:
  - The port and the bit are absent, and no halt flag exists.
  - redirect_pc[1:0] and RESET_PC[1:0] are forced to 2'b00 when loaded into pc.

Test Plan:
- Reset release, out_ready=1, memory holds 32'h0010_0313 at address 0 and 32'h0063_0333 at address 4 -> cycle 1: out_valid=1, out_pc=0, out_inst=32'h0010_0313, out_pc4=4; cycle 2: out_pc=4, out_inst=32'h0063_0333.
- out_ready=0 for 5 cycles after reset, FIFO_DEPTH=2 -> count saturates at 2, imem_addr stalls at 8, head stays out_pc=0; out_ready=1 -> out_pc sequence 0, 4, 8 on consecutive cycles with no gaps or duplicates.
- Redirect to 32'h0000_0040 while the FIFO is full and out_ready=0 -> out_valid=0 next cycle; the following cycle out_valid=1 with out_pc=32'h40; the old entries at 0 and 4 never appear.
- Redirect to 32'hFFFF_FFFC, out_ready=1 -> out_pc sequence FFFF_FFFC, 0000_0000; out_pc4 for the first entry=0.
- Assert rst mid-stream with count=2 -> next cycle out_valid=0, imem_addr=RESET_PC, out_inst=32'h0000_0013.
- With FETCH_MISALIGN_EN, redirect to 32'h0000_0042 -> one entry with out_misalign=1 and out_inst=32'h0000_0013, then no more pushes; redirect to 32'h44 resumes fetching. Without the macro, the same stimulus fetches from 32'h40.
